// File: rtl/dec_ex_core.sv
// dec_ex_core
//   Three-stage MIPS32 integer subset core: D (decode + register read),
//   E1 (ALU, 32x32 multiplier, branch resolve), E2 (HI/LO accumulator,
//   result select). No stalls and no internal forwarding.
//
// Ports
//   Clock        rising-edge clock
//   nReset       asynchronous active-low reset
//   Instr        instruction in D (0x00000000 = NOP)
//   InstrAddr    16-bit byte address of Instr
//   WbEn/WbAddr/WbData  register-file write port (r0 ignored)
//   RegAddr      debug read index
//   RegData      combinational debug read (write-through)
//   Result/ResultAddr/ResultWrite  E2 result, two edges after Instr
//   BranchTaken/BranchAddr         E1 redirect, one edge after Instr

module dec_ex_core (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [31:0] Instr,
  input  logic [15:0] InstrAddr,
  input  logic        WbEn,
  input  logic [4:0]  WbAddr,
  input  logic [31:0] WbData,
  input  logic [4:0]  RegAddr,
  output logic [31:0] RegData,
  output logic [31:0] Result,
  output logic [4:0]  ResultAddr,
  output logic        ResultWrite,
  output logic        BranchTaken,
  output logic [15:0] BranchAddr
);

  typedef enum logic [3:0] {
    K_NONE, K_ALU, K_MUL_S, K_MUL_U, K_MADD,
    K_MFHI, K_MFLO, K_BEQ, K_BNE, K_J
  } kind_t;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_NOR,
    A_SLT, A_SLTU, A_SLL, A_SRL, A_SRA
  } alu_op_t;

  // ---------------------------------------------------------------
  // Register file: flop array so the whole file clears on reset and
  // reads are combinational.
  // ---------------------------------------------------------------
  logic [31:0] regs [32];
  logic        wb_en_nz;

  assign wb_en_nz = WbEn && (WbAddr != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rf
      always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
          regs[gi] <= '0;
        else if (wb_en_nz && (WbAddr == 5'(gi)))
          regs[gi] <= WbData;
      end
    end
  endgenerate

  // Field extraction
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = Instr[31:26];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign shamt = Instr[10:6];
  assign funct = Instr[5:0];
  assign imm   = Instr[15:0];

  // Read ports with write-through of the same-cycle writeback
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (wb_en_nz && WbAddr == rs) ? WbData : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (wb_en_nz && WbAddr == rt) ? WbData : regs[rt];

  // Debug read forced to zero while reset is held so a pending
  // writeback cannot leak through the bypass.
  assign RegData = (!nReset || RegAddr == 5'd0) ? 32'd0 :
                   (wb_en_nz && WbAddr == RegAddr) ? WbData : regs[RegAddr];

  // ---------------------------------------------------------------
  // D stage decode
  // ---------------------------------------------------------------
  kind_t       d_kind;
  alu_op_t     d_alu_op;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [4:0]  d_dest;
  logic [15:0] d_target;

  always_comb begin
    d_kind   = K_NONE;
    d_alu_op = A_ADD;
    d_a      = rs_val;
    d_b      = rt_val;
    d_dest   = 5'd0;
    d_target = 16'd0;
    case (op)
      6'h00: begin
        d_dest = rd;
        case (funct)
          6'h21: begin d_kind = K_ALU; d_alu_op = A_ADD;  end
          6'h23: begin d_kind = K_ALU; d_alu_op = A_SUB;  end
          6'h24: begin d_kind = K_ALU; d_alu_op = A_AND;  end
          6'h25: begin d_kind = K_ALU; d_alu_op = A_OR;   end
          6'h26: begin d_kind = K_ALU; d_alu_op = A_XOR;  end
          6'h27: begin d_kind = K_ALU; d_alu_op = A_NOR;  end
          6'h2A: begin d_kind = K_ALU; d_alu_op = A_SLT;  end
          6'h2B: begin d_kind = K_ALU; d_alu_op = A_SLTU; end
          6'h00: begin d_kind = K_ALU; d_alu_op = A_SLL;  end
          6'h02: begin d_kind = K_ALU; d_alu_op = A_SRL;  end
          6'h03: begin d_kind = K_ALU; d_alu_op = A_SRA;  end
          6'h18: d_kind = K_MUL_S;
          6'h19: d_kind = K_MUL_U;
          6'h10: d_kind = K_MFHI;
          6'h12: d_kind = K_MFLO;
          default: d_kind = K_NONE;
        endcase
      end
      6'h1C: if (funct == 6'h00) d_kind = K_MADD;
      6'h09: begin
        d_kind = K_ALU; d_alu_op = A_ADD;
        d_b = {{16{imm[15]}}, imm}; d_dest = rt;
      end
      6'h0A: begin
        d_kind = K_ALU; d_alu_op = A_SLT;
        d_b = {{16{imm[15]}}, imm}; d_dest = rt;
      end
      6'h0C: begin
        d_kind = K_ALU; d_alu_op = A_AND;
        d_b = {16'd0, imm}; d_dest = rt;
      end
      6'h0D: begin
        d_kind = K_ALU; d_alu_op = A_OR;
        d_b = {16'd0, imm}; d_dest = rt;
      end
      6'h0E: begin
        d_kind = K_ALU; d_alu_op = A_XOR;
        d_b = {16'd0, imm}; d_dest = rt;
      end
      6'h0F: begin
        // LUI as 0 | (imm << 16)
        d_kind = K_ALU; d_alu_op = A_OR;
        d_a = 32'd0; d_b = {imm, 16'd0}; d_dest = rt;
      end
      6'h04: begin
        d_kind = K_BEQ;
        // Low 16 bits of sign-extended imm<<2 are just imm[13:0],2'b00
        d_target = InstrAddr + 16'd4 + {imm[13:0], 2'b00};
      end
      6'h05: begin
        d_kind = K_BNE;
        d_target = InstrAddr + 16'd4 + {imm[13:0], 2'b00};
      end
      6'h02: begin
        d_kind = K_J;
        d_target = {Instr[13:0], 2'b00};
      end
      default: d_kind = K_NONE;
    endcase
    // Only result-producing instructions carry a destination; this also
    // makes undefined encodings and r0 targets non-writing.
    if (!(d_kind inside {K_ALU, K_MFHI, K_MFLO}))
      d_dest = 5'd0;
  end

  // ---------------------------------------------------------------
  // D -> E1 pipeline register
  // ---------------------------------------------------------------
  kind_t       e1_kind;
  alu_op_t     e1_alu_op;
  logic [31:0] e1_a;
  logic [31:0] e1_b;
  logic [4:0]  e1_shamt;
  logic [4:0]  e1_dest;
  logic [15:0] e1_target;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      e1_kind   <= K_NONE;
      e1_alu_op <= A_ADD;
      e1_a      <= '0;
      e1_b      <= '0;
      e1_shamt  <= '0;
      e1_dest   <= '0;
      e1_target <= '0;
    end else begin
      e1_kind   <= d_kind;
      e1_alu_op <= d_alu_op;
      e1_a      <= d_a;
      e1_b      <= d_b;
      e1_shamt  <= shamt;
      e1_dest   <= d_dest;
      e1_target <= d_target;
    end
  end

  // ---------------------------------------------------------------
  // E1: ALU, multiplier, branch
  // ---------------------------------------------------------------
  logic [31:0] alu_res;

  always_comb begin
    alu_res = 32'd0;
    case (e1_alu_op)
      A_ADD:  alu_res = e1_a + e1_b;
      A_SUB:  alu_res = e1_a - e1_b;
      A_AND:  alu_res = e1_a & e1_b;
      A_OR:   alu_res = e1_a | e1_b;
      A_XOR:  alu_res = e1_a ^ e1_b;
      A_NOR:  alu_res = ~(e1_a | e1_b);
      A_SLT:  alu_res = {31'd0, $signed(e1_a) < $signed(e1_b)};
      A_SLTU: alu_res = {31'd0, e1_a < e1_b};
      A_SLL:  alu_res = e1_b << e1_shamt;
      A_SRL:  alu_res = e1_b >> e1_shamt;
      A_SRA:  alu_res = $unsigned($signed(e1_b) >>> e1_shamt);
      default: alu_res = 32'd0;
    endcase
  end

  // One 64x64 multiplier: the low 64 bits of the product of the
  // sign- or zero-extended operands are the exact 32x32 result.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_prod;

  assign mul_signed = (e1_kind == K_MUL_S) || (e1_kind == K_MADD);
  assign mul_a      = {{32{mul_signed & e1_a[31]}}, e1_a};
  assign mul_b      = {{32{mul_signed & e1_b[31]}}, e1_b};
  assign mul_prod   = mul_a * mul_b;

  logic branch_taken;

  assign branch_taken = ((e1_kind == K_BEQ) && (e1_a == e1_b)) ||
                        ((e1_kind == K_BNE) && (e1_a != e1_b)) ||
                        (e1_kind == K_J);

  assign BranchTaken = branch_taken;
  assign BranchAddr  = branch_taken ? e1_target : 16'd0;

  // ---------------------------------------------------------------
  // E1 -> E2 pipeline register
  // ---------------------------------------------------------------
  kind_t       e2_kind;
  logic [31:0] e2_alu;
  logic [4:0]  e2_dest;
  logic        e2_write;
  logic [63:0] e2_prod;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      e2_kind  <= K_NONE;
      e2_alu   <= '0;
      e2_dest  <= '0;
      e2_write <= 1'b0;
      e2_prod  <= '0;
    end else begin
      e2_kind  <= e1_kind;
      e2_alu   <= alu_res;
      e2_dest  <= e1_dest;
      e2_write <= (e1_dest != 5'd0);
      e2_prod  <= mul_prod;
    end
  end

  // ---------------------------------------------------------------
  // E2: HI/LO accumulator and result select. An MFHI/MFLO that
  // directly follows a multiply enters E2 on the same edge that loads
  // HI/LO, so reading the registers here is already back-to-back safe.
  // ---------------------------------------------------------------
  logic [31:0] hi;
  logic [31:0] lo;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (e2_kind)
        K_MUL_S, K_MUL_U: {hi, lo} <= e2_prod;
        K_MADD:           {hi, lo} <= {hi, lo} + e2_prod;
        default:          ;
      endcase
    end
  end

  logic [31:0] e2_value;

  always_comb begin
    case (e2_kind)
      K_MFHI:  e2_value = hi;
      K_MFLO:  e2_value = lo;
      default: e2_value = e2_alu;
    endcase
  end

  assign Result      = e2_write ? e2_value : 32'd0;
  assign ResultAddr  = e2_dest;
  assign ResultWrite = e2_write;

endmodule

// File: tb/tb_dec_ex_core.sv
// tb_dec_ex_core
//   Directed bench for dec_ex_core: each task drives a scenario and
//   compares outputs against hand-computed values one edge (branch) or
//   two edges (result) after the instruction is presented.

module tb_dec_ex_core;

  logic        Clock;
  logic        nReset;
  logic [31:0] Instr;
  logic [15:0] InstrAddr;
  logic        WbEn;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic [4:0]  RegAddr;
  logic [31:0] RegData;
  logic [31:0] Result;
  logic [4:0]  ResultAddr;
  logic        ResultWrite;
  logic        BranchTaken;
  logic [15:0] BranchAddr;

  int checks = 0;
  int errors = 0;

  dec_ex_core dut (
    .Clock(Clock), .nReset(nReset), .Instr(Instr), .InstrAddr(InstrAddr),
    .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData), .RegAddr(RegAddr),
    .RegData(RegData), .Result(Result), .ResultAddr(ResultAddr),
    .ResultWrite(ResultWrite), .BranchTaken(BranchTaken),
    .BranchAddr(BranchAddr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    WbEn = 1'b1; WbAddr = a; WbData = d;
    tick();
    WbEn = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Instr = 32'h24010005; InstrAddr = 16'h0;
    WbEn = 1'b1; WbAddr = 5'd1; WbData = 32'hCAFEF00D; RegAddr = 5'd1;
    #1;
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", Result); end
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", ResultWrite); end
    checks++; if (BranchTaken !== 1'b0) begin errors++; $display("FAIL reset_branch got %b want 0", BranchTaken); end
    checks++; if (RegData !== 32'd0) begin errors++; $display("FAIL reset_regdata got %h want 0", RegData); end
    repeat (2) @(posedge Clock);
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL reset_held_write got %b want 0", ResultWrite); end
    WbEn = 1'b0; Instr = 32'h0;
    #3 nReset = 1'b1;
  endtask

  task automatic test_addiu();
    Instr = 32'h24010005;
    tick();
    Instr = 32'h0;
    tick();
    checks++; if (Result !== 32'd5) begin errors++; $display("FAIL addiu_result got %h want 5", Result); end
    checks++; if (ResultAddr !== 5'd1) begin errors++; $display("FAIL addiu_addr got %0d want 1", ResultAddr); end
    checks++; if (ResultWrite !== 1'b1) begin errors++; $display("FAIL addiu_write got %b want 1", ResultWrite); end
    wb_write(5'd1, 32'd5);
    RegAddr = 5'd1; #1;
    checks++; if (RegData !== 32'd5) begin errors++; $display("FAIL addiu_regdata got %h want 5", RegData); end
    // combinational write-through on the debug port
    WbEn = 1'b1; WbAddr = 5'd3; WbData = 32'h0BADF00D; RegAddr = 5'd3; #1;
    checks++; if (RegData !== 32'h0BADF00D) begin errors++; $display("FAIL regdata_bypass got %h want 0badf00d", RegData); end
    WbEn = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] vi [20];
    logic [31:0] ve [20];
    logic [4:0]  va [20];
    logic        vw [20];
    wb_write(5'd1, 32'hFFFFFFFD);
    wb_write(5'd2, 32'd7);
    vi = '{32'h00221821, 32'h00221823, 32'h00221824, 32'h00221825, 32'h00221826,
           32'h00221827, 32'h0022182A, 32'h0022182B, 32'h00021900, 32'h00011902,
           32'h00011903, 32'h2425FFFF, 32'h2825FFFE, 32'h3025FFFF, 32'h34451230,
           32'h3845000F, 32'h3C06ABCD, 32'hFC221821, 32'h00221801, 32'h00220018};
    ve = '{32'd4, 32'hFFFFFFF6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFA,
           32'd0, 32'd1, 32'd0, 32'h70, 32'h0FFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFC, 32'd1, 32'h0000FFFD, 32'h1237,
           32'd8, 32'hABCD0000, 32'd0, 32'd0, 32'd0};
    va = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3,
           5'd3, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0};
    vw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      Instr = vi[i];
      tick();
      Instr = 32'h0;
      tick();
      $display("alu instr=%h result=%h addr=%0d write=%b", vi[i], Result, ResultAddr, ResultWrite);
      checks++; if (Result !== ve[i]) begin errors++; $display("FAIL alu_result[%0d] got %h want %h", i, Result, ve[i]); end
      checks++; if (ResultAddr !== va[i]) begin errors++; $display("FAIL alu_addr[%0d] got %0d want %0d", i, ResultAddr, va[i]); end
      checks++; if (ResultWrite !== vw[i]) begin errors++; $display("FAIL alu_write[%0d] got %b want %b", i, ResultWrite, vw[i]); end
    end
  endtask

  task automatic test_back_to_back();
    // D-stage write-through: r9 written on the same edge ADDIU reads it
    WbEn = 1'b1; WbAddr = 5'd9; WbData = 32'h12345678;
    Instr = 32'h252A0001;
    tick();
    WbEn = 1'b0;
    Instr = 32'h34070011;
    tick();
    checks++; if (Result !== 32'h12345679) begin errors++; $display("FAIL d_bypass_result got %h want 12345679", Result); end
    checks++; if (ResultAddr !== 5'd10) begin errors++; $display("FAIL d_bypass_addr got %0d want 10", ResultAddr); end
    Instr = 32'h34080022;
    tick();
    Instr = 32'h0;
    checks++; if (Result !== 32'h11 || ResultAddr !== 5'd7) begin errors++; $display("FAIL b2b_first got %h/%0d want 11/7", Result, ResultAddr); end
    tick();
    checks++; if (Result !== 32'h22 || ResultAddr !== 5'd8) begin errors++; $display("FAIL b2b_second got %h/%0d want 22/8", Result, ResultAddr); end
  endtask

  task automatic test_mult();
    Instr = 32'h00220018;   // MULT r1,r2
    tick();
    Instr = 32'h00001812;   // MFLO r3
    tick();
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL mult_write got %b want 0", ResultWrite); end
    Instr = 32'h00002010;   // MFHI r4
    tick();
    Instr = 32'h0;
    checks++; if (Result !== 32'hFFFFFFEB || ResultAddr !== 5'd3) begin errors++; $display("FAIL mult_lo got %h/%0d want ffffffeb/3", Result, ResultAddr); end
    tick();
    checks++; if (Result !== 32'hFFFFFFFF || ResultAddr !== 5'd4) begin errors++; $display("FAIL mult_hi got %h/%0d want ffffffff/4", Result, ResultAddr); end
    // MADD r1,r2 accumulates onto the HI/LO just loaded
    Instr = 32'h70220000;
    tick();
    Instr = 32'h00001812;
    tick();
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL madd_write got %b want 0", ResultWrite); end
    Instr = 32'h00002010;
    tick();
    Instr = 32'h0;
    checks++; if (Result !== 32'hFFFFFFD6) begin errors++; $display("FAIL madd_lo got %h want ffffffd6", Result); end
    tick();
    checks++; if (Result !== 32'hFFFFFFFF) begin errors++; $display("FAIL madd_hi got %h want ffffffff", Result); end
    // MULTU r1,r2 replaces HI/LO: 0xFFFFFFFD*7 = 0x6_FFFFFFEB
    Instr = 32'h00220019;
    tick();
    Instr = 32'h00002010;
    tick();
    Instr = 32'h00001812;
    tick();
    Instr = 32'h0;
    checks++; if (Result !== 32'h00000006) begin errors++; $display("FAIL multu_hi got %h want 6", Result); end
    tick();
    checks++; if (Result !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_lo got %h want ffffffeb", Result); end
  endtask

  task automatic test_branch();
    InstrAddr = 16'h0010; Instr = 32'h10000003;   // BEQ r0,r0,3
    tick();
    checks++; if (BranchTaken !== 1'b1 || BranchAddr !== 16'h0020) begin errors++; $display("FAIL beq_taken got %b/%h want 1/0020", BranchTaken, BranchAddr); end
    Instr = 32'h14000003;                          // BNE r0,r0,3
    tick();
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL beq_write got %b want 0", ResultWrite); end
    checks++; if (BranchTaken !== 1'b0 || BranchAddr !== 16'h0000) begin errors++; $display("FAIL bne_not_taken got %b/%h want 0/0000", BranchTaken, BranchAddr); end
    InstrAddr = 16'h0100; Instr = 32'h1422FFFC;   // BNE r1,r2,-4
    tick();
    checks++; if (BranchTaken !== 1'b1 || BranchAddr !== 16'h00F4) begin errors++; $display("FAIL bne_back got %b/%h want 1/00f4", BranchTaken, BranchAddr); end
    Instr = 32'h10220003;                          // BEQ r1,r2 not taken
    tick();
    checks++; if (BranchTaken !== 1'b0 || BranchAddr !== 16'h0000) begin errors++; $display("FAIL beq_not_taken got %b/%h want 0/0000", BranchTaken, BranchAddr); end
    Instr = 32'h08000040;                          // J 0x40
    tick();
    checks++; if (BranchTaken !== 1'b1 || BranchAddr !== 16'h0100) begin errors++; $display("FAIL j_small got %b/%h want 1/0100", BranchTaken, BranchAddr); end
    Instr = 32'h0BFFFFFF;                          // J max index, truncated
    tick();
    Instr = 32'h0;
    checks++; if (BranchTaken !== 1'b1 || BranchAddr !== 16'hFFFC) begin errors++; $display("FAIL j_trunc got %b/%h want 1/fffc", BranchTaken, BranchAddr); end
    tick();
    checks++; if (BranchTaken !== 1'b0 || BranchAddr !== 16'h0000) begin errors++; $display("FAIL nop_branch got %b/%h want 0/0000", BranchTaken, BranchAddr); end
  endtask

  task automatic test_r0();
    WbEn = 1'b1; WbAddr = 5'd0; WbData = 32'hDEADBEEF; RegAddr = 5'd0; #1;
    checks++; if (RegData !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h want 0", RegData); end
    tick();
    WbEn = 1'b0; #1;
    checks++; if (RegData !== 32'd0) begin errors++; $display("FAIL r0_stored got %h want 0", RegData); end
    Instr = 32'h24000001;   // ADDIU r0,r0,1
    tick();
    Instr = 32'h0;
    tick();
    checks++; if (ResultWrite !== 1'b0 || Result !== 32'd0) begin errors++; $display("FAIL r0_dest got %b/%h want 0/0", ResultWrite, Result); end
  endtask

  task automatic test_async_reset();
    Instr = 32'h24010005;   // ADDIU r1,r0,5
    tick();
    Instr = 32'h08000040;   // J 0x40
    tick();
    Instr = 32'h24010005;   // in flight when reset hits
    checks++; if (ResultWrite !== 1'b1 || BranchTaken !== 1'b1) begin errors++; $display("FAIL pre_reset got %b/%b want 1/1", ResultWrite, BranchTaken); end
    #3 nReset = 1'b0;
    #1;
    checks++; if (Result !== 32'd0 || ResultAddr !== 5'd0 || ResultWrite !== 1'b0) begin errors++; $display("FAIL async_result got %h/%0d/%b want 0/0/0", Result, ResultAddr, ResultWrite); end
    checks++; if (BranchTaken !== 1'b0 || BranchAddr !== 16'h0) begin errors++; $display("FAIL async_branch got %b/%h want 0/0000", BranchTaken, BranchAddr); end
    RegAddr = 5'd2; #1;
    checks++; if (RegData !== 32'd0) begin errors++; $display("FAIL async_regdata got %h want 0", RegData); end
    Instr = 32'h0;
    #1 nReset = 1'b1;
    tick();
    tick();
    checks++; if (ResultWrite !== 1'b0) begin errors++; $display("FAIL discard_write got %b want 0", ResultWrite); end
    checks++; if (RegData !== 32'd0) begin errors++; $display("FAIL cleared_r2 got %h want 0", RegData); end
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_alu();
    test_back_to_back();
    test_mult();
    test_branch();
    test_r0();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
